// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: entry layout, drain states,
// pointer sizing and byte-lane geometry.
package store_buffer_pkg;

  localparam int MAX_ADDR_W = 32;
  localparam int MAX_DATA_W = 32;
  localparam int LANE_W     = 8;
  localparam int LANE_SEL_W = 2;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
    logic                  is_byte;
    logic                  valid;
  } sb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  // Pointer width carries one extra wrap bit beyond the entry index.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store/load/drain signal bundle between the M stage, the store buffer and the
// data memory controller.
interface store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
);
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_byte;
  logic              st_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_byte;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_conflict;
  logic              dm_req;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_data;
  logic              dm_byte;
  logic              dm_ack;
  logic              drain_all;
  logic              empty;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  st_valid, st_addr, st_data, st_byte, ld_valid, ld_addr, ld_byte,
           dm_ack, drain_all,
    output st_ready, ld_hit, ld_data, ld_conflict, dm_req, dm_addr, dm_data,
           dm_byte, empty, count
  );

  modport master (
    output st_valid, st_addr, st_data, st_byte, ld_valid, ld_addr, ld_byte,
           dm_ack, drain_all,
    input  st_ready, ld_hit, ld_data, ld_conflict, dm_req, dm_addr, dm_data,
           dm_byte, empty, count
  );
endinterface

// File: rtl/store_buffer_match.sv
// Combinational load lookup: per-entry overlap/cover compare with the youngest
// overlapping entry deciding between a forward hit and a partial conflict.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int PTR_W  = ptr_w(DEPTH),
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  sb_entry_t         ent [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [PTR_W-1:0]  tail,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_byte,
  output logic              hit,
  output logic              conflict,
  output logic [DATA_W-1:0] data
);

  logic [PTR_W-1:0]  occ;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  sel;
  logic              found;
  logic              overlap;
  logic [ADDR_W-1:0] ea;
  logic [LANE_W-1:0] lane_byte;

  assign occ = tail - head;

  // Walk oldest to youngest so the last overlapping entry seen wins.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    idx     = '0;
    overlap = 1'b0;
    ea      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx     = head[IDX_W-1:0] + IDX_W'(k);
      ea      = ent[idx].addr[ADDR_W-1:0];
      overlap = (ent[idx].is_byte && ld_byte) ? (ea == ld_addr)
              : (ea[ADDR_W-1:LANE_SEL_W] == ld_addr[ADDR_W-1:LANE_SEL_W]);
      if ((PTR_W'(k) < occ) && ent[idx].valid && overlap) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    hit       = 1'b0;
    conflict  = 1'b0;
    data      = '0;
    lane_byte = ent[sel].data[ld_addr[LANE_SEL_W-1:0]*LANE_W +: LANE_W];
    if (ld_valid && found) begin
      if (!ent[sel].is_byte || ld_byte) begin
        hit = 1'b1;
        if (!ld_byte)              data = ent[sel].data[DATA_W-1:0];
        else if (ent[sel].is_byte) data = DATA_W'(ent[sel].data[LANE_W-1:0]);
        else                       data = DATA_W'(lane_byte);
      end else begin
        conflict = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: circular FIFO of retired stores, drained to data
// memory over req/ack, with store-to-load forwarding and conflict reporting.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LAZY_DRAIN = 0,
  parameter int HIGH_WATER = 3
) (
  input  logic          clock,
  input  logic          reset,
  store_buffer_if.slave bus
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);

  sb_entry_t        ent [DEPTH];
  logic [PTR_W-1:0] head, tail, occ, occ_next;
  logic [IDX_W-1:0] head_idx, tail_idx;
  drain_state_e     state, state_next;
  logic             st_ready_q, push, pop, dm_req, drain_en, ld_conflict;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign occ      = tail - head;
  assign dm_req   = (state == DRAIN);
  assign push     = bus.st_valid && st_ready_q;
  assign pop      = bus.dm_ack && dm_req;
  assign occ_next = occ + PTR_W'(push) - PTR_W'(pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      st_ready_q <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (push) begin
        ent[tail_idx] <= '{addr:    MAX_ADDR_W'(bus.st_addr),
                           data:    MAX_DATA_W'(bus.st_data),
                           is_byte: bus.st_byte,
                           valid:   1'b1};
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        ent[head_idx].valid <= 1'b0;
        head <= head + PTR_W'(1);
      end
      st_ready_q <= (occ_next != PTR_W'(DEPTH));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Transitions look at post-edge occupancy so dm_req never asserts on an
  // empty buffer and drops on the same edge that pops the last entry.
  always_comb begin
    state_next = state;
    drain_en   = (LAZY_DRAIN != 0)
               ? ((occ_next >= PTR_W'(HIGH_WATER)) || bus.drain_all || ld_conflict)
               : 1'b1;
    unique case (state)
      IDLE:    if (drain_en && (occ_next != '0)) state_next = DRAIN;
      DRAIN:   if ((occ_next == '0) || !drain_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  store_buffer_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_match (
    .ent      (ent),
    .head     (head),
    .tail     (tail),
    .ld_valid (bus.ld_valid),
    .ld_addr  (bus.ld_addr),
    .ld_byte  (bus.ld_byte),
    .hit      (bus.ld_hit),
    .conflict (ld_conflict),
    .data     (bus.ld_data)
  );

  assign bus.ld_conflict = ld_conflict;
  assign bus.st_ready    = st_ready_q;
  assign bus.dm_req      = dm_req;
  assign bus.dm_addr     = ent[head_idx].addr[ADDR_W-1:0];
  assign bus.dm_data     = ent[head_idx].data[DATA_W-1:0];
  assign bus.dm_byte     = ent[head_idx].is_byte;
  assign bus.empty       = (head == tail);
  assign bus.count       = occ;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: an eager and a lazy instance, directed scenarios and
// a randomized run against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  store_buffer_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) be ();
  store_buffer_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) bl ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .LAZY_DRAIN(0), .HIGH_WATER(3))
    u_eager (.clock(clock), .reset(reset), .bus(be));
  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .LAZY_DRAIN(1), .HIGH_WATER(3))
    u_lazy (.clock(clock), .reset(reset), .bus(bl));

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          is_byte;
  } ment_t;

  ment_t q[$];  // eager instance contents, oldest first

  task automatic idle_inputs();
    be.st_valid = 0; be.st_addr = '0; be.st_data = '0; be.st_byte = 0;
    be.ld_valid = 0; be.ld_addr = '0; be.ld_byte = 0; be.dm_ack = 0; be.drain_all = 0;
    bl.st_valid = 0; bl.st_addr = '0; bl.st_data = '0; bl.st_byte = 0;
    bl.ld_valid = 0; bl.ld_addr = '0; bl.ld_byte = 0; bl.dm_ack = 0; bl.drain_all = 0;
  endtask

  // One clock: the eager model pops/pushes from the inputs seen before the edge.
  task automatic tick();
    ment_t e;
    bit    push, pop;
    if (be.st_valid && q.size() == DEPTH)
      $display("note: store request while buffer full is a protocol violation (dropped)");
    push = be.st_valid && (q.size() < DEPTH);
    pop  = be.dm_ack && (q.size() != 0);
    e.addr = be.st_addr; e.data = be.st_data; e.is_byte = be.st_byte;
    @(posedge clock); #1;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(e);
  endtask

  function automatic void model_fwd(input logic [31:0] a, input bit b,
                                    output bit hit, output bit conf, output logic [31:0] d);
    bit done, ov;
    hit = 0; conf = 0; d = '0; done = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!done) begin
        ov = (q[i].is_byte && b) ? (q[i].addr == a) : (q[i].addr[31:2] == a[31:2]);
        if (ov) begin
          done = 1;
          if (!q[i].is_byte || b) begin
            hit = 1;
            if (!b)            d = q[i].data;
            else if (q[i].is_byte) d = {24'h0, q[i].data[7:0]};
            else               d = (q[i].data >> (8 * a[1:0])) & 32'hFF;
          end else conf = 1;
        end
      end
    end
  endfunction

  task automatic test_reset();
    be.st_valid = 1; be.st_addr = 32'h10; be.st_data = 32'h1; tick();
    be.st_addr = 32'h14; be.st_data = 32'h2; tick();
    be.st_valid = 0; #1;
    checks++; if (be.dm_req !== 1'b1) begin errors++; $display("FAIL reset_pre_dmreq: got %0b want 1", be.dm_req); end
    checks++; if (be.count !== 3'd2) begin errors++; $display("FAIL reset_pre_count: got %0d want 2", be.count); end
    reset = 0; #1;
    checks++; if (be.dm_req !== 1'b0) begin errors++; $display("FAIL reset_async_dmreq: got %0b want 0", be.dm_req); end
    q.delete();
    @(posedge clock); #1;
    reset = 1;
    be.ld_valid = 1; be.ld_addr = 32'h10; be.ld_byte = 0; #1;
    checks++; if (be.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", be.empty); end
    checks++; if (be.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", be.count); end
    checks++; if (be.st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready: got %0b want 1", be.st_ready); end
    checks++; if (be.dm_req !== 1'b0) begin errors++; $display("FAIL reset_dm_req: got %0b want 0", be.dm_req); end
    checks++; if ({be.ld_hit, be.ld_conflict} !== 2'b00) begin errors++; $display("FAIL reset_ld_flags: got %b want 00", {be.ld_hit, be.ld_conflict}); end
    checks++; if (be.ld_data !== 32'h0) begin errors++; $display("FAIL reset_ld_data: got %h want 0", be.ld_data); end
    checks++; if (bl.empty !== 1'b1) begin errors++; $display("FAIL reset_lazy_empty: got %0b want 1", bl.empty); end
    be.ld_valid = 0;
  endtask

  task automatic test_eager_drain();
    be.st_valid = 1; be.st_addr = 32'h100; be.st_data = 32'hDEADBEEF; be.st_byte = 0; tick();
    be.st_valid = 0; #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (be.dm_req !== 1'b1) begin errors++; $display("FAIL drain_req_c%0d: got %0b want 1", c, be.dm_req); end
      checks++; if (be.dm_addr !== 32'h100) begin errors++; $display("FAIL drain_addr_c%0d: got %h want 100", c, be.dm_addr); end
      checks++; if (be.dm_data !== 32'hDEADBEEF) begin errors++; $display("FAIL drain_data_c%0d: got %h want deadbeef", c, be.dm_data); end
      tick();
    end
    be.dm_ack = 1; tick(); be.dm_ack = 0; #1;
    checks++; if (be.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b want 1", be.empty); end
    checks++; if (be.dm_req !== 1'b0) begin errors++; $display("FAIL drain_req_after: got %0b want 0", be.dm_req); end
  endtask

  task automatic test_full();
    int guard;
    be.dm_ack = 0;
    for (int i = 0; i < 4; i++) begin
      be.st_valid = 1; be.st_addr = 32'h40 + 32'(4 * i); be.st_data = $urandom; be.st_byte = 0; tick();
    end
    be.st_valid = 0; #1;
    checks++; if (be.st_ready !== 1'b0) begin errors++; $display("FAIL full_st_ready: got %0b want 0", be.st_ready); end
    checks++; if (be.count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", be.count); end
    be.st_valid = 1; be.st_addr = 32'h80; be.st_data = 32'h0BAD0BAD; tick();
    be.st_valid = 0; #1;
    checks++; if (be.count !== 3'd4) begin errors++; $display("FAIL full_drop_count: got %0d want 4", be.count); end
    be.st_valid = 1; be.st_addr = 32'h84; be.st_data = 32'h0BAD0BAE; be.dm_ack = 1; tick();
    be.st_valid = 0; be.dm_ack = 0; #1;
    checks++; if (be.count !== 3'd3) begin errors++; $display("FAIL full_store_ack_count: got %0d want 3", be.count); end
    checks++; if (be.st_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise: got %0b want 1", be.st_ready); end
    be.st_valid = 1; be.st_addr = 32'h88; be.st_data = 32'h12345678; be.dm_ack = 1; tick();
    be.st_valid = 0; #1;
    checks++; if (be.count !== 3'd3) begin errors++; $display("FAIL push_pop_count: got %0d want 3", be.count); end
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      checks++; if (be.dm_data !== q[0].data) begin errors++; $display("FAIL full_drain_order: got %h want %h", be.dm_data, q[0].data); end
      tick(); guard++;
    end
    be.dm_ack = 0; #1;
    checks++; if (be.empty !== 1'b1) begin errors++; $display("FAIL full_drained_empty: got %0b want 1", be.empty); end
  endtask

  task automatic test_forward();
    be.dm_ack = 0;
    be.st_valid = 1; be.st_addr = 32'h200; be.st_data = 32'h11223344; be.st_byte = 0; tick();
    be.st_data = 32'hAABBCCDD; tick();
    be.st_valid = 0;
    be.ld_valid = 1; be.ld_addr = 32'h201; be.ld_byte = 1; #1;
    checks++; if (be.ld_hit !== 1'b1) begin errors++; $display("FAIL fwd_byte_hit: got %0b want 1", be.ld_hit); end
    checks++; if (be.ld_data !== 32'h000000CC) begin errors++; $display("FAIL fwd_byte_data: got %h want 000000cc", be.ld_data); end
    be.ld_addr = 32'h203; #1;
    checks++; if (be.ld_data !== 32'h000000AA) begin errors++; $display("FAIL fwd_byte3_data: got %h want 000000aa", be.ld_data); end
    be.ld_addr = 32'h200; be.ld_byte = 0; #1;
    checks++; if (be.ld_data !== 32'hAABBCCDD) begin errors++; $display("FAIL fwd_word_data: got %h want aabbccdd", be.ld_data); end
    be.ld_addr = 32'h205; be.ld_byte = 1; #1;
    checks++; if ({be.ld_hit, be.ld_conflict, be.ld_data} !== 34'h0) begin errors++; $display("FAIL fwd_miss: got %b/%b/%h want 0/0/0", be.ld_hit, be.ld_conflict, be.ld_data); end
    be.ld_valid = 0; be.ld_addr = 32'h200; be.ld_byte = 0; #1;
    checks++; if (be.ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_ld_invalid: got %0b want 0", be.ld_hit); end
    be.dm_ack = 1; tick();
    be.ld_valid = 1; #1;
    checks++; if (be.ld_hit !== 1'b1 || be.ld_data !== 32'hAABBCCDD) begin errors++; $display("FAIL fwd_popping: got %0b/%h want 1/aabbccdd", be.ld_hit, be.ld_data); end
    tick(); be.dm_ack = 0; #1;
    checks++; if (be.ld_hit !== 1'b0 || be.empty !== 1'b1) begin errors++; $display("FAIL fwd_after_pop: got hit %0b empty %0b want 0 1", be.ld_hit, be.empty); end
    be.ld_valid = 0;
  endtask

  task automatic test_conflict_lazy();
    bl.st_valid = 1; bl.st_addr = 32'h302; bl.st_data = 32'h5A; bl.st_byte = 1; tick();
    bl.st_valid = 0; #1;
    checks++; if (bl.count !== 3'd1 || bl.dm_req !== 1'b0) begin errors++; $display("FAIL conf_pre: got count %0d req %0b want 1 0", bl.count, bl.dm_req); end
    bl.ld_valid = 1; bl.ld_addr = 32'h302; bl.ld_byte = 1; #1;
    checks++; if (bl.ld_hit !== 1'b1 || bl.ld_data !== 32'h5A) begin errors++; $display("FAIL conf_byte_hit: got %0b/%h want 1/5a", bl.ld_hit, bl.ld_data); end
    bl.ld_addr = 32'h300; bl.ld_byte = 0; #1;
    checks++; if (bl.ld_conflict !== 1'b1 || bl.ld_hit !== 1'b0) begin errors++; $display("FAIL conf_flag: got conf %0b hit %0b want 1 0", bl.ld_conflict, bl.ld_hit); end
    tick();
    checks++; if (bl.dm_req !== 1'b1 || bl.dm_addr !== 32'h302 || bl.dm_byte !== 1'b1) begin errors++; $display("FAIL conf_drain: got req %0b addr %h byte %0b want 1 302 1", bl.dm_req, bl.dm_addr, bl.dm_byte); end
    checks++; if (bl.ld_conflict !== 1'b1) begin errors++; $display("FAIL conf_hold: got %0b want 1", bl.ld_conflict); end
    bl.dm_ack = 1; tick(); bl.dm_ack = 0; #1;
    checks++; if (bl.ld_conflict !== 1'b0 || bl.count !== 3'd0 || bl.dm_req !== 1'b0) begin errors++; $display("FAIL conf_clear: got conf %0b count %0d req %0b want 0 0 0", bl.ld_conflict, bl.count, bl.dm_req); end
    bl.ld_valid = 0;
  endtask

  task automatic test_lazy_drain();
    for (int i = 0; i < 3; i++) begin
      bl.st_valid = 1; bl.st_addr = 32'h500 + 32'(4 * i); bl.st_data = 32'hC0DE0000 + 32'(i); bl.st_byte = 0; tick();
      bl.st_valid = 0; #1;
      if (i == 1) begin
        checks++; if (bl.dm_req !== 1'b0 || bl.count !== 3'd2) begin errors++; $display("FAIL lazy_below_hw: got req %0b count %0d want 0 2", bl.dm_req, bl.count); end
      end
    end
    checks++; if (bl.dm_req !== 1'b1 || bl.dm_addr !== 32'h500) begin errors++; $display("FAIL lazy_at_hw: got req %0b addr %h want 1 500", bl.dm_req, bl.dm_addr); end
    bl.dm_ack = 1; tick();
    checks++; if (bl.count !== 3'd2 || bl.dm_req !== 1'b0) begin errors++; $display("FAIL lazy_stop: got count %0d req %0b want 2 0", bl.count, bl.dm_req); end
    tick();
    checks++; if (bl.count !== 3'd2) begin errors++; $display("FAIL lazy_stray_ack: got %0d want 2", bl.count); end
    bl.dm_ack = 0; bl.drain_all = 1; tick();
    checks++; if (bl.dm_req !== 1'b1 || bl.dm_addr !== 32'h504) begin errors++; $display("FAIL lazy_drain_all: got req %0b addr %h want 1 504", bl.dm_req, bl.dm_addr); end
    bl.dm_ack = 1; tick();
    checks++; if (bl.count !== 3'd1 || bl.dm_req !== 1'b1 || bl.dm_addr !== 32'h508) begin errors++; $display("FAIL lazy_drain_mid: got count %0d req %0b addr %h want 1 1 508", bl.count, bl.dm_req, bl.dm_addr); end
    tick();
    checks++; if (bl.empty !== 1'b1 || bl.dm_req !== 1'b0) begin errors++; $display("FAIL lazy_drain_done: got empty %0b req %0b want 1 0", bl.empty, bl.dm_req); end
    bl.dm_ack = 0; bl.drain_all = 0;
  endtask

  task automatic test_random();
    bit          e_hit, e_conf;
    logic [31:0] e_data;
    for (int n = 0; n < 400; n++) begin
      be.st_valid = ($urandom_range(0, 2) != 0) && (q.size() < DEPTH);
      be.st_addr  = 32'h400 + 32'($urandom_range(0, 7));
      be.st_byte  = $urandom_range(0, 1);
      be.st_data  = $urandom;
      be.dm_ack   = $urandom_range(0, 1);
      be.ld_valid = ($urandom_range(0, 3) != 0);
      be.ld_addr  = 32'h400 + 32'($urandom_range(0, 7));
      be.ld_byte  = $urandom_range(0, 1);
      #1;
      model_fwd(be.ld_addr, be.ld_byte, e_hit, e_conf, e_data);
      if (!be.ld_valid) begin e_hit = 0; e_conf = 0; end
      checks++; if (be.count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count n=%0d: got %0d want %0d", n, be.count, q.size()); end
      checks++; if (be.st_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_st_ready n=%0d: got %0b want %0b", n, be.st_ready, q.size() < DEPTH); end
      checks++; if (be.dm_req !== (q.size() != 0)) begin errors++; $display("FAIL rnd_dm_req n=%0d: got %0b want %0b", n, be.dm_req, q.size() != 0); end
      if (q.size() != 0) begin
        checks++;
        if (be.dm_addr !== q[0].addr || be.dm_data !== q[0].data || be.dm_byte !== q[0].is_byte) begin
          errors++; $display("FAIL rnd_head n=%0d: got %h/%h/%0b want %h/%h/%0b", n, be.dm_addr, be.dm_data, be.dm_byte, q[0].addr, q[0].data, q[0].is_byte);
        end
      end
      checks++; if (be.ld_hit !== e_hit || be.ld_conflict !== e_conf) begin errors++; $display("FAIL rnd_ld_flags n=%0d: got %0b%0b want %0b%0b", n, be.ld_hit, be.ld_conflict, e_hit, e_conf); end
      if (be.ld_valid) begin
        checks++; if (be.ld_data !== e_data) begin errors++; $display("FAIL rnd_ld_data n=%0d: got %h want %h", n, be.ld_data, e_data); end
      end
      tick();
    end
    idle_inputs();
    be.dm_ack = 1;
    for (int g = 0; g < 8 && q.size() != 0; g++) tick();
    be.dm_ack = 0; #1;
    checks++; if (be.empty !== 1'b1) begin errors++; $display("FAIL rnd_final_empty: got %0b want 1", be.empty); end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 1;
    test_reset();
    test_eager_drain();
    test_full();
    test_forward();
    test_conflict_lazy();
    test_lazy_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
